// File: rtl/nasti_buf_pkg.sv
// Field widths and payload-width helpers shared by the NASTI channel buffer.
package nasti_buf_pkg;

  localparam int LEN    = 8;
  localparam int SIZE   = 3;
  localparam int BURST  = 2;
  localparam int CACHE  = 4;
  localparam int PROT   = 3;
  localparam int QOS    = 4;
  localparam int REGION = 4;
  localparam int RESP   = 2;

  // An illegal configuration yields width 0, which breaks elaboration loudly.
  function automatic bit widths_ok(input int id_w, input int addr_w, input int data_w, input int user_w);
    return (id_w > 0) && (addr_w > 0) && (data_w > 0) && (data_w % 8 == 0) && (user_w > 0);
  endfunction

  function automatic int aw_width(input int id_w, input int addr_w, input int data_w, input int user_w);
    return widths_ok(id_w, addr_w, data_w, user_w) ?
           id_w + addr_w + LEN + SIZE + BURST + 1 + CACHE + PROT + QOS + REGION + user_w : 0;
  endfunction

  function automatic int ar_width(input int id_w, input int addr_w, input int data_w, input int user_w);
    return aw_width(id_w, addr_w, data_w, user_w);
  endfunction

  function automatic int w_width(input int id_w, input int addr_w, input int data_w, input int user_w);
    return widths_ok(id_w, addr_w, data_w, user_w) ? data_w + data_w / 8 + 1 + user_w : 0;
  endfunction

  function automatic int b_width(input int id_w, input int addr_w, input int data_w, input int user_w);
    return widths_ok(id_w, addr_w, data_w, user_w) ? id_w + RESP + user_w : 0;
  endfunction

  function automatic int r_width(input int id_w, input int addr_w, input int data_w, input int user_w);
    return widths_ok(id_w, addr_w, data_w, user_w) ? id_w + data_w + RESP + 1 + user_w : 0;
  endfunction

  function automatic int cnt_width(input int depth);
    return (depth == 0) ? 1 : $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/nasti_buf_fifo.sv
// One-channel valid/ready FIFO; DEPTH=0 is a wire, 1-cycle latency otherwise.
// NASTI_BUF_FALLTHROUGH_EN lets an empty FIFO forward the input beat combinationally.
module nasti_buf_fifo
  import nasti_buf_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  localparam int CW = cnt_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    count
);

  if (DEPTH == 0) begin : g_wire
    assign out_valid = in_valid & ~rst;
    assign in_ready  = out_ready & ~rst;
    assign out_data  = in_data;
    assign count     = '0;
  end else begin : g_fifo
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr, wr_ptr;
    logic [CW-1:0]    cnt_q;
    logic             empty, full, push, pop, bypass;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign empty    = (cnt_q == '0);
    assign full     = (cnt_q == CW'(DEPTH));
    assign in_ready = ~full & ~rst;

`ifdef NASTI_BUF_FALLTHROUGH_EN
    assign bypass    = empty & in_valid & out_ready & ~rst;
    assign out_valid = ~empty | (in_valid & ~rst);
    assign out_data  = empty ? in_data : mem[rd_ptr];
`else
    assign bypass    = 1'b0;
    assign out_valid = ~empty;
    assign out_data  = mem[rd_ptr];
`endif

    // A bypassed beat never touches storage, so it is neither a push nor a pop.
    assign push  = in_valid & in_ready & ~bypass;
    assign pop   = out_valid & out_ready & ~bypass;
    assign count = cnt_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        cnt_q  <= '0;
      end else begin
        if (push) wr_ptr <= next_ptr(wr_ptr);
        if (pop)  rd_ptr <= next_ptr(rd_ptr);
        case ({push, pop})
          2'b10:   cnt_q <= cnt_q + CW'(1);
          2'b01:   cnt_q <= cnt_q - CW'(1);
          default: ;
        endcase
      end
    end

    always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= in_data;
    end
  end

endmodule

// File: rtl/nasti_buf.sv
// Five independent per-channel FIFOs between a NASTI master and slave; optional
// NASTI_BUF_FALLTHROUGH_EN gives zero-latency bypass on empty channels.
module nasti_buf
  import nasti_buf_pkg::*;
#(
  parameter int ID_WIDTH   = 1,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int USER_WIDTH = 1,
  parameter int AW_DEPTH   = 2,
  parameter int W_DEPTH    = 2,
  parameter int B_DEPTH    = 2,
  parameter int AR_DEPTH   = 2,
  parameter int R_DEPTH    = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          s_aw_valid,
  output logic                          s_aw_ready,
  input  logic [ID_WIDTH-1:0]           s_aw_id,
  input  logic [ADDR_WIDTH-1:0]         s_aw_addr,
  input  logic [LEN-1:0]                s_aw_len,
  input  logic [SIZE-1:0]               s_aw_size,
  input  logic [BURST-1:0]              s_aw_burst,
  input  logic                          s_aw_lock,
  input  logic [CACHE-1:0]              s_aw_cache,
  input  logic [PROT-1:0]               s_aw_prot,
  input  logic [QOS-1:0]                s_aw_qos,
  input  logic [REGION-1:0]             s_aw_region,
  input  logic [USER_WIDTH-1:0]         s_aw_user,
  output logic                          m_aw_valid,
  input  logic                          m_aw_ready,
  output logic [ID_WIDTH-1:0]           m_aw_id,
  output logic [ADDR_WIDTH-1:0]         m_aw_addr,
  output logic [LEN-1:0]                m_aw_len,
  output logic [SIZE-1:0]               m_aw_size,
  output logic [BURST-1:0]              m_aw_burst,
  output logic                          m_aw_lock,
  output logic [CACHE-1:0]              m_aw_cache,
  output logic [PROT-1:0]               m_aw_prot,
  output logic [QOS-1:0]                m_aw_qos,
  output logic [REGION-1:0]             m_aw_region,
  output logic [USER_WIDTH-1:0]         m_aw_user,
  input  logic                          s_w_valid,
  output logic                          s_w_ready,
  input  logic [DATA_WIDTH-1:0]         s_w_data,
  input  logic [DATA_WIDTH/8-1:0]       s_w_strb,
  input  logic                          s_w_last,
  input  logic [USER_WIDTH-1:0]         s_w_user,
  output logic                          m_w_valid,
  input  logic                          m_w_ready,
  output logic [DATA_WIDTH-1:0]         m_w_data,
  output logic [DATA_WIDTH/8-1:0]       m_w_strb,
  output logic                          m_w_last,
  output logic [USER_WIDTH-1:0]         m_w_user,
  output logic                          s_b_valid,
  input  logic                          s_b_ready,
  output logic [ID_WIDTH-1:0]           s_b_id,
  output logic [RESP-1:0]               s_b_resp,
  output logic [USER_WIDTH-1:0]         s_b_user,
  input  logic                          m_b_valid,
  output logic                          m_b_ready,
  input  logic [ID_WIDTH-1:0]           m_b_id,
  input  logic [RESP-1:0]               m_b_resp,
  input  logic [USER_WIDTH-1:0]         m_b_user,
  input  logic                          s_ar_valid,
  output logic                          s_ar_ready,
  input  logic [ID_WIDTH-1:0]           s_ar_id,
  input  logic [ADDR_WIDTH-1:0]         s_ar_addr,
  input  logic [LEN-1:0]                s_ar_len,
  input  logic [SIZE-1:0]               s_ar_size,
  input  logic [BURST-1:0]              s_ar_burst,
  input  logic                          s_ar_lock,
  input  logic [CACHE-1:0]              s_ar_cache,
  input  logic [PROT-1:0]               s_ar_prot,
  input  logic [QOS-1:0]                s_ar_qos,
  input  logic [REGION-1:0]             s_ar_region,
  input  logic [USER_WIDTH-1:0]         s_ar_user,
  output logic                          m_ar_valid,
  input  logic                          m_ar_ready,
  output logic [ID_WIDTH-1:0]           m_ar_id,
  output logic [ADDR_WIDTH-1:0]         m_ar_addr,
  output logic [LEN-1:0]                m_ar_len,
  output logic [SIZE-1:0]               m_ar_size,
  output logic [BURST-1:0]              m_ar_burst,
  output logic                          m_ar_lock,
  output logic [CACHE-1:0]              m_ar_cache,
  output logic [PROT-1:0]               m_ar_prot,
  output logic [QOS-1:0]                m_ar_qos,
  output logic [REGION-1:0]             m_ar_region,
  output logic [USER_WIDTH-1:0]         m_ar_user,
  output logic                          s_r_valid,
  input  logic                          s_r_ready,
  output logic [ID_WIDTH-1:0]           s_r_id,
  output logic [DATA_WIDTH-1:0]         s_r_data,
  output logic [RESP-1:0]               s_r_resp,
  output logic                          s_r_last,
  output logic [USER_WIDTH-1:0]         s_r_user,
  input  logic                          m_r_valid,
  output logic                          m_r_ready,
  input  logic [ID_WIDTH-1:0]           m_r_id,
  input  logic [DATA_WIDTH-1:0]         m_r_data,
  input  logic [RESP-1:0]               m_r_resp,
  input  logic                          m_r_last,
  input  logic [USER_WIDTH-1:0]         m_r_user,
  output logic [cnt_width(AW_DEPTH)-1:0] aw_count,
  output logic [cnt_width(W_DEPTH)-1:0]  w_count,
  output logic [cnt_width(B_DEPTH)-1:0]  b_count,
  output logic [cnt_width(AR_DEPTH)-1:0] ar_count,
  output logic [cnt_width(R_DEPTH)-1:0]  r_count
);

  localparam int AWW = aw_width(ID_WIDTH, ADDR_WIDTH, DATA_WIDTH, USER_WIDTH);
  localparam int WW  = w_width(ID_WIDTH, ADDR_WIDTH, DATA_WIDTH, USER_WIDTH);
  localparam int BW  = b_width(ID_WIDTH, ADDR_WIDTH, DATA_WIDTH, USER_WIDTH);
  localparam int ARW = ar_width(ID_WIDTH, ADDR_WIDTH, DATA_WIDTH, USER_WIDTH);
  localparam int RW  = r_width(ID_WIDTH, ADDR_WIDTH, DATA_WIDTH, USER_WIDTH);

  logic [AWW-1:0] aw_in, aw_out;
  logic [WW-1:0]  w_in, w_out;
  logic [BW-1:0]  b_in, b_out;
  logic [ARW-1:0] ar_in, ar_out;
  logic [RW-1:0]  r_in, r_out;

  // Fields packed MSB first in declaration order.
  assign aw_in = {s_aw_id, s_aw_addr, s_aw_len, s_aw_size, s_aw_burst, s_aw_lock,
                  s_aw_cache, s_aw_prot, s_aw_qos, s_aw_region, s_aw_user};
  assign {m_aw_id, m_aw_addr, m_aw_len, m_aw_size, m_aw_burst, m_aw_lock,
          m_aw_cache, m_aw_prot, m_aw_qos, m_aw_region, m_aw_user} = aw_out;
  assign w_in = {s_w_data, s_w_strb, s_w_last, s_w_user};
  assign {m_w_data, m_w_strb, m_w_last, m_w_user} = w_out;
  assign b_in = {m_b_id, m_b_resp, m_b_user};
  assign {s_b_id, s_b_resp, s_b_user} = b_out;
  assign ar_in = {s_ar_id, s_ar_addr, s_ar_len, s_ar_size, s_ar_burst, s_ar_lock,
                  s_ar_cache, s_ar_prot, s_ar_qos, s_ar_region, s_ar_user};
  assign {m_ar_id, m_ar_addr, m_ar_len, m_ar_size, m_ar_burst, m_ar_lock,
          m_ar_cache, m_ar_prot, m_ar_qos, m_ar_region, m_ar_user} = ar_out;
  assign r_in = {m_r_id, m_r_data, m_r_resp, m_r_last, m_r_user};
  assign {s_r_id, s_r_data, s_r_resp, s_r_last, s_r_user} = r_out;

  nasti_buf_fifo #(.WIDTH(AWW), .DEPTH(AW_DEPTH)) u_aw (
    .clk, .rst, .in_valid(s_aw_valid), .in_ready(s_aw_ready), .in_data(aw_in),
    .out_valid(m_aw_valid), .out_ready(m_aw_ready), .out_data(aw_out), .count(aw_count));

  nasti_buf_fifo #(.WIDTH(WW), .DEPTH(W_DEPTH)) u_w (
    .clk, .rst, .in_valid(s_w_valid), .in_ready(s_w_ready), .in_data(w_in),
    .out_valid(m_w_valid), .out_ready(m_w_ready), .out_data(w_out), .count(w_count));

  nasti_buf_fifo #(.WIDTH(BW), .DEPTH(B_DEPTH)) u_b (
    .clk, .rst, .in_valid(m_b_valid), .in_ready(m_b_ready), .in_data(b_in),
    .out_valid(s_b_valid), .out_ready(s_b_ready), .out_data(b_out), .count(b_count));

  nasti_buf_fifo #(.WIDTH(ARW), .DEPTH(AR_DEPTH)) u_ar (
    .clk, .rst, .in_valid(s_ar_valid), .in_ready(s_ar_ready), .in_data(ar_in),
    .out_valid(m_ar_valid), .out_ready(m_ar_ready), .out_data(ar_out), .count(ar_count));

  nasti_buf_fifo #(.WIDTH(RW), .DEPTH(R_DEPTH)) u_r (
    .clk, .rst, .in_valid(m_r_valid), .in_ready(m_r_ready), .in_data(r_in),
    .out_valid(s_r_valid), .out_ready(s_r_ready), .out_data(r_out), .count(r_count));

endmodule

// File: tb/tb_nasti_buf.sv
// Queue-model bench for nasti_buf: directed channel scenarios plus random traffic.
module tb_nasti_buf;
  import nasti_buf_pkg::*;

  localparam int IW = 4, AD = 8, DW = 8, UW = 1;
  localparam int AWD = 2, WD = 4, BD = 1, ARD = 2, RD = 3;
  localparam int AWP = aw_width(IW, AD, DW, UW);
  localparam int WP  = w_width(IW, AD, DW, UW);
  localparam int BP  = b_width(IW, AD, DW, UW);
  localparam int RP  = r_width(IW, AD, DW, UW);
`ifdef NASTI_BUF_FALLTHROUGH_EN
  localparam bit FT = 1'b1;
`else
  localparam bit FT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic s_aw_valid, s_aw_ready, m_aw_valid, m_aw_ready, s_aw_lock, m_aw_lock;
  logic [IW-1:0] s_aw_id, m_aw_id;
  logic [AD-1:0] s_aw_addr, m_aw_addr;
  logic [LEN-1:0] s_aw_len, m_aw_len;
  logic [SIZE-1:0] s_aw_size, m_aw_size;
  logic [BURST-1:0] s_aw_burst, m_aw_burst;
  logic [CACHE-1:0] s_aw_cache, m_aw_cache;
  logic [PROT-1:0] s_aw_prot, m_aw_prot;
  logic [QOS-1:0] s_aw_qos, m_aw_qos;
  logic [REGION-1:0] s_aw_region, m_aw_region;
  logic [UW-1:0] s_aw_user, m_aw_user;
  logic s_w_valid, s_w_ready, m_w_valid, m_w_ready, s_w_last, m_w_last;
  logic [DW-1:0] s_w_data, m_w_data;
  logic [DW/8-1:0] s_w_strb, m_w_strb;
  logic [UW-1:0] s_w_user, m_w_user;
  logic s_b_valid, s_b_ready, m_b_valid, m_b_ready;
  logic [IW-1:0] s_b_id, m_b_id;
  logic [RESP-1:0] s_b_resp, m_b_resp;
  logic [UW-1:0] s_b_user, m_b_user;
  logic s_ar_valid, s_ar_ready, m_ar_valid, m_ar_ready, s_ar_lock, m_ar_lock;
  logic [IW-1:0] s_ar_id, m_ar_id;
  logic [AD-1:0] s_ar_addr, m_ar_addr;
  logic [LEN-1:0] s_ar_len, m_ar_len;
  logic [SIZE-1:0] s_ar_size, m_ar_size;
  logic [BURST-1:0] s_ar_burst, m_ar_burst;
  logic [CACHE-1:0] s_ar_cache, m_ar_cache;
  logic [PROT-1:0] s_ar_prot, m_ar_prot;
  logic [QOS-1:0] s_ar_qos, m_ar_qos;
  logic [REGION-1:0] s_ar_region, m_ar_region;
  logic [UW-1:0] s_ar_user, m_ar_user;
  logic s_r_valid, s_r_ready, m_r_valid, m_r_ready, s_r_last, m_r_last;
  logic [IW-1:0] s_r_id, m_r_id;
  logic [DW-1:0] s_r_data, m_r_data;
  logic [RESP-1:0] s_r_resp, m_r_resp;
  logic [UW-1:0] s_r_user, m_r_user;
  logic [cnt_width(AWD)-1:0] aw_count;
  logic [cnt_width(WD)-1:0]  w_count;
  logic [cnt_width(BD)-1:0]  b_count;
  logic [cnt_width(ARD)-1:0] ar_count;
  logic [cnt_width(RD)-1:0]  r_count;

  nasti_buf #(.ID_WIDTH(IW), .ADDR_WIDTH(AD), .DATA_WIDTH(DW), .USER_WIDTH(UW),
              .AW_DEPTH(AWD), .W_DEPTH(WD), .B_DEPTH(BD), .AR_DEPTH(ARD), .R_DEPTH(RD)) dut (
    .clk(clk), .rst(rst),
    .s_aw_valid(s_aw_valid), .s_aw_ready(s_aw_ready), .s_aw_id(s_aw_id), .s_aw_addr(s_aw_addr),
    .s_aw_len(s_aw_len), .s_aw_size(s_aw_size), .s_aw_burst(s_aw_burst), .s_aw_lock(s_aw_lock),
    .s_aw_cache(s_aw_cache), .s_aw_prot(s_aw_prot), .s_aw_qos(s_aw_qos), .s_aw_region(s_aw_region),
    .s_aw_user(s_aw_user),
    .m_aw_valid(m_aw_valid), .m_aw_ready(m_aw_ready), .m_aw_id(m_aw_id), .m_aw_addr(m_aw_addr),
    .m_aw_len(m_aw_len), .m_aw_size(m_aw_size), .m_aw_burst(m_aw_burst), .m_aw_lock(m_aw_lock),
    .m_aw_cache(m_aw_cache), .m_aw_prot(m_aw_prot), .m_aw_qos(m_aw_qos), .m_aw_region(m_aw_region),
    .m_aw_user(m_aw_user),
    .s_w_valid(s_w_valid), .s_w_ready(s_w_ready), .s_w_data(s_w_data), .s_w_strb(s_w_strb),
    .s_w_last(s_w_last), .s_w_user(s_w_user),
    .m_w_valid(m_w_valid), .m_w_ready(m_w_ready), .m_w_data(m_w_data), .m_w_strb(m_w_strb),
    .m_w_last(m_w_last), .m_w_user(m_w_user),
    .s_b_valid(s_b_valid), .s_b_ready(s_b_ready), .s_b_id(s_b_id), .s_b_resp(s_b_resp),
    .s_b_user(s_b_user),
    .m_b_valid(m_b_valid), .m_b_ready(m_b_ready), .m_b_id(m_b_id), .m_b_resp(m_b_resp),
    .m_b_user(m_b_user),
    .s_ar_valid(s_ar_valid), .s_ar_ready(s_ar_ready), .s_ar_id(s_ar_id), .s_ar_addr(s_ar_addr),
    .s_ar_len(s_ar_len), .s_ar_size(s_ar_size), .s_ar_burst(s_ar_burst), .s_ar_lock(s_ar_lock),
    .s_ar_cache(s_ar_cache), .s_ar_prot(s_ar_prot), .s_ar_qos(s_ar_qos), .s_ar_region(s_ar_region),
    .s_ar_user(s_ar_user),
    .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready), .m_ar_id(m_ar_id), .m_ar_addr(m_ar_addr),
    .m_ar_len(m_ar_len), .m_ar_size(m_ar_size), .m_ar_burst(m_ar_burst), .m_ar_lock(m_ar_lock),
    .m_ar_cache(m_ar_cache), .m_ar_prot(m_ar_prot), .m_ar_qos(m_ar_qos), .m_ar_region(m_ar_region),
    .m_ar_user(m_ar_user),
    .s_r_valid(s_r_valid), .s_r_ready(s_r_ready), .s_r_id(s_r_id), .s_r_data(s_r_data),
    .s_r_resp(s_r_resp), .s_r_last(s_r_last), .s_r_user(s_r_user),
    .m_r_valid(m_r_valid), .m_r_ready(m_r_ready), .m_r_id(m_r_id), .m_r_data(m_r_data),
    .m_r_resp(m_r_resp), .m_r_last(m_r_last), .m_r_user(m_r_user),
    .aw_count(aw_count), .w_count(w_count), .b_count(b_count), .ar_count(ar_count), .r_count(r_count)
  );

  // Whole-beat views of each side, independent of the DUT's internal packing.
  logic [63:0] aw_i, aw_o, w_i, w_o, b_i, b_o, ar_i, ar_o, r_i, r_o;
  assign aw_i = 64'({s_aw_id, s_aw_addr, s_aw_len, s_aw_size, s_aw_burst, s_aw_lock,
                     s_aw_cache, s_aw_prot, s_aw_qos, s_aw_region, s_aw_user});
  assign aw_o = 64'({m_aw_id, m_aw_addr, m_aw_len, m_aw_size, m_aw_burst, m_aw_lock,
                     m_aw_cache, m_aw_prot, m_aw_qos, m_aw_region, m_aw_user});
  assign w_i  = 64'({s_w_data, s_w_strb, s_w_last, s_w_user});
  assign w_o  = 64'({m_w_data, m_w_strb, m_w_last, m_w_user});
  assign b_i  = 64'({m_b_id, m_b_resp, m_b_user});
  assign b_o  = 64'({s_b_id, s_b_resp, s_b_user});
  assign ar_i = 64'({s_ar_id, s_ar_addr, s_ar_len, s_ar_size, s_ar_burst, s_ar_lock,
                     s_ar_cache, s_ar_prot, s_ar_qos, s_ar_region, s_ar_user});
  assign ar_o = 64'({m_ar_id, m_ar_addr, m_ar_len, m_ar_size, m_ar_burst, m_ar_lock,
                     m_ar_cache, m_ar_prot, m_ar_qos, m_ar_region, m_ar_user});
  assign r_i  = 64'({m_r_id, m_r_data, m_r_resp, m_r_last, m_r_user});
  assign r_o  = 64'({s_r_id, s_r_data, s_r_resp, s_r_last, s_r_user});

  int checks = 0;
  int fails = 0;
  logic [63:0] mq [5][$];

  task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: a bounded queue per channel; decides outputs now and the next-edge update.
  task automatic chk(input int c, input string nm, input int depth,
                     input logic ivld, input logic irdy, input logic [63:0] idat,
                     input logic ovld, input logic ordy, input logic [63:0] odat, input int cnt);
    int n;
    logic er, ev, push, pop;
    n  = mq[c].size();
    er = !rst && (n < depth);
    ev = (n != 0) || (FT && ivld && !rst);
    cmp({nm, "_in_ready"}, 64'(irdy), 64'(er));
    cmp({nm, "_out_valid"}, 64'(ovld), 64'(ev));
    cmp({nm, "_count"}, 64'(cnt), 64'(n));
    if (ev) cmp({nm, "_out_data"}, odat, (n != 0) ? mq[c][0] : idat);
    if (rst) begin
      mq[c].delete();
    end else begin
      push = ivld && er;
      pop  = ev && ordy;
      if (!(push && pop && n == 0)) begin
        if (pop)  void'(mq[c].pop_front());
        if (push) mq[c].push_back(idat);
      end
    end
  endtask

  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      chk(0, "aw", AWD, s_aw_valid, s_aw_ready, aw_i, m_aw_valid, m_aw_ready, aw_o, int'(aw_count));
      chk(1, "w",  WD,  s_w_valid,  s_w_ready,  w_i,  m_w_valid,  m_w_ready,  w_o,  int'(w_count));
      chk(2, "b",  BD,  m_b_valid,  m_b_ready,  b_i,  s_b_valid,  s_b_ready,  b_o,  int'(b_count));
      chk(3, "ar", ARD, s_ar_valid, s_ar_ready, ar_i, m_ar_valid, m_ar_ready, ar_o, int'(ar_count));
      chk(4, "r",  RD,  m_r_valid,  m_r_ready,  r_i,  s_r_valid,  s_r_ready,  r_o,  int'(r_count));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic idle_all();
    s_aw_valid = 1'b0; s_w_valid = 1'b0; m_b_valid = 1'b0; s_ar_valid = 1'b0; m_r_valid = 1'b0;
    m_aw_ready = 1'b1; m_w_ready = 1'b1; s_b_ready = 1'b1; m_ar_ready = 1'b1; s_r_ready = 1'b1;
  endtask

  task automatic rnd_all();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    {s_aw_id, s_aw_addr, s_aw_len, s_aw_size, s_aw_burst, s_aw_lock,
     s_aw_cache, s_aw_prot, s_aw_qos, s_aw_region, s_aw_user} = r[AWP-1:0];
    r = {$urandom(), $urandom()};
    {s_ar_id, s_ar_addr, s_ar_len, s_ar_size, s_ar_burst, s_ar_lock,
     s_ar_cache, s_ar_prot, s_ar_qos, s_ar_region, s_ar_user} = r[AWP-1:0];
    r = {$urandom(), $urandom()};
    {s_w_data, s_w_strb, s_w_last, s_w_user} = r[WP-1:0];
    {m_b_id, m_b_resp, m_b_user} = r[WP+BP-1:WP];
    r = {$urandom(), $urandom()};
    {m_r_id, m_r_data, m_r_resp, m_r_last, m_r_user} = r[RP-1:0];
    s_aw_valid = 1'($urandom_range(0, 1)); m_aw_ready = 1'($urandom_range(0, 1));
    s_w_valid  = 1'($urandom_range(0, 1)); m_w_ready  = 1'($urandom_range(0, 1));
    m_b_valid  = 1'($urandom_range(0, 1)); s_b_ready  = 1'($urandom_range(0, 1));
    s_ar_valid = 1'($urandom_range(0, 1)); m_ar_ready = 1'($urandom_range(0, 1));
    m_r_valid  = 1'($urandom_range(0, 1)); s_r_ready  = 1'($urandom_range(0, 1));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int sent, got, maxc, hs;
  logic acc;

  initial begin
    idle_all();
    {s_aw_id, s_aw_addr, s_aw_len, s_aw_size, s_aw_burst, s_aw_lock,
     s_aw_cache, s_aw_prot, s_aw_qos, s_aw_region, s_aw_user} = '0;
    {s_ar_id, s_ar_addr, s_ar_len, s_ar_size, s_ar_burst, s_ar_lock,
     s_ar_cache, s_ar_prot, s_ar_qos, s_ar_region, s_ar_user} = '0;
    {s_w_data, s_w_strb, s_w_last, s_w_user} = '0;
    {m_b_id, m_b_resp, m_b_user} = '0;
    {m_r_id, m_r_data, m_r_resp, m_r_last, m_r_user} = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    cmp("rst_aw_ready", 64'(s_aw_ready), 64'd0);
    cmp("rst_r_valid", 64'(s_r_valid), 64'd0);
    cmp("rst_w_count", 64'(w_count), 64'd0);
    step(); rst = 1'b0;
    @(negedge clk);
    cmp("rel_w_ready", 64'(s_w_ready), 64'd1);
    cmp("rel_b_ready", 64'(m_b_ready), 64'd1);

    // AW: fill depth 2 against a stalled slave, then drain.
    step(); m_aw_ready = 1'b0; s_aw_valid = 1'b1; s_aw_addr = 8'h10; s_aw_id = 4'd3; s_aw_len = 8'h07;
    step(); s_aw_addr = 8'h20; s_aw_id = 4'd4; s_aw_len = 8'h01;
    step(); s_aw_valid = 1'b0;
    @(negedge clk);
    cmp("aw_full_count", 64'(aw_count), 64'd2);
    cmp("aw_full_ready", 64'(s_aw_ready), 64'd0);
    step(); m_aw_ready = 1'b1;
    @(negedge clk);
    cmp("aw_first_addr", 64'(m_aw_addr), 64'h10);
    cmp("aw_first_id", 64'(m_aw_id), 64'd3);
    cmp("aw_first_len", 64'(m_aw_len), 64'h07);
    step();
    @(negedge clk);
    cmp("aw_second_addr", 64'(m_aw_addr), 64'h20);
    cmp("aw_second_id", 64'(m_aw_id), 64'd4);
    step();
    @(negedge clk);
    cmp("aw_drained_valid", 64'(m_aw_valid), 64'd0);

    // W: 8-beat burst at full rate.
    for (int k = 1; k <= 8; k++) begin
      step(); s_w_valid = 1'b1; s_w_data = DW'(k); s_w_strb = 1'b1; s_w_last = (k == 8); s_w_user = 1'b0;
      @(negedge clk);
      if (k >= 2) begin
        cmp("w_stream_data", 64'(m_w_data), FT ? 64'(k) : 64'(k - 1));
        cmp("w_stream_count", 64'(w_count), FT ? 64'd0 : 64'd1);
      end
    end
    step(); s_w_valid = 1'b0; s_w_last = 1'b0;
    @(negedge clk);
`ifdef NASTI_BUF_FALLTHROUGH_EN
    cmp("w_tail_valid", 64'(m_w_valid), 64'd0);
`else
    cmp("w_tail_data", 64'(m_w_data), 64'd8);
    cmp("w_tail_last", 64'(m_w_last), 64'd1);
`endif

    // R: random stalls on both sides across pointer wrap.
    sent = 0; got = 0; maxc = 0; acc = 1'b0;
    for (int cy = 0; cy < 400 && got < 20; cy++) begin
      step();
      if (acc) m_r_valid = 1'b0;
      if (!m_r_valid && sent < 20) m_r_valid = 1'($urandom_range(0, 1));
      m_r_id = 4'd5; m_r_data = DW'(sent); m_r_last = (sent == 19); m_r_resp = '0; m_r_user = '0;
      s_r_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (int'(r_count) > maxc) maxc = int'(r_count);
      if (s_r_valid && s_r_ready) begin
        cmp("r_order_data", 64'(s_r_data), 64'(got));
        cmp("r_order_id", 64'(s_r_id), 64'd5);
        got++;
      end
      acc = m_r_valid && m_r_ready;
      if (acc) sent++;
    end
    cmp("r_beats_delivered", 64'(got), 64'd20);
    cmp("r_count_bound", 64'(maxc > RD), 64'd0);
    step(); m_r_valid = 1'b0; s_r_ready = 1'b1;

    // B: depth-1 throughput, then reset with one beat held.
    hs = 0;
    step(); m_b_valid = 1'b1; m_b_id = 4'd7; m_b_resp = 2'd1;
    for (int cy = 0; cy < 20; cy++) begin
      @(negedge clk);
      if (s_b_valid && s_b_ready) hs++;
      step();
    end
    cmp("b_throughput", 64'(hs), FT ? 64'd20 : 64'd10);
    s_b_ready = 1'b0; m_b_id = 4'd9;
    step(); m_b_valid = 1'b0;
    @(negedge clk);
    cmp("b_held_valid", 64'(s_b_valid), 64'd1);
    cmp("b_held_id", 64'(s_b_id), 64'd9);
    step(); rst = 1'b1;
    step();
    @(negedge clk);
    cmp("b_rst_valid", 64'(s_b_valid), 64'd0);
    cmp("b_rst_count", 64'(b_count), 64'd0);
    step(); rst = 1'b0; s_b_ready = 1'b1;

    // AR: single beat into an empty channel with the slave ready.
    step(); m_ar_ready = 1'b1; s_ar_valid = 1'b1; s_ar_addr = 8'hA5;
    @(negedge clk);
`ifdef NASTI_BUF_FALLTHROUGH_EN
    cmp("ar_ft_valid", 64'(m_ar_valid), 64'd1);
    cmp("ar_ft_addr", 64'(m_ar_addr), 64'hA5);
    cmp("ar_ft_count", 64'(ar_count), 64'd0);
`else
    cmp("ar_lat_valid", 64'(m_ar_valid), 64'd0);
`endif
    step(); s_ar_valid = 1'b0;
    @(negedge clk);
`ifdef NASTI_BUF_FALLTHROUGH_EN
    cmp("ar_ft_after", 64'(m_ar_valid), 64'd0);
`else
    cmp("ar_lat_addr", 64'(m_ar_addr), 64'hA5);
    cmp("ar_lat_count", 64'(ar_count), 64'd1);
`endif

    // Random traffic on every channel at once.
    for (int cy = 0; cy < 300; cy++) begin
      step();
      rnd_all();
    end
    step(); idle_all();
    repeat (10) step();
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
